// File: rtl/lbus_regfile.sv
// LBUS register bank: ID/scratch/ctrl, W1C irq status with mask, optional hw-to-host byte FIFO (LBUS_REGFILE_FIFO_EN).
// rdata is combinational from address; writes, pushes and pops land at clk; irq is registered from status & mask.
module lbus_regfile #(
    parameter logic [15:0] BASE_ADDR  = 16'h0000,
    parameter logic [7:0]  ID_VALUE   = 8'hA5,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic        wr_en,
    input  logic [7:0]  wdata,
    input  logic        rd_en,
    output logic [7:0]  rdata,
    input  logic [6:0]  evt,
    input  logic        push_valid,
    input  logic [7:0]  push_data,
    output logic        fifo_full,
    output logic [7:0]  ctrl,
    output logic        irq
);

    logic [15:0] off;
    logic [7:0]  scratch_q, scratch_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  mask_q, mask_d;
    logic        irq_q, irq_d;
    logic        ovf;
    logic [7:0]  fifo_level;
    logic [7:0]  fifo_head;

    // Addresses below BASE_ADDR wrap to huge offsets and fall into the unmapped default.
    assign off = address - BASE_ADDR;

`ifdef LBUS_REGFILE_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_hit, rd_hit_q;
    logic          empty, full, do_pop, do_push;

    assign rd_hit = rd_en && (off == 16'd6);
    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_C);
    // Pop on the falling edge of a FIFO_DATA read so the master has already sampled the head.
    assign do_pop  = rd_hit_q && !rd_hit && !empty;
    assign do_push = push_valid && (!full || do_pop);
    assign ovf     = push_valid && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        fifo_level        = '0;
        fifo_level[AW:0]  = count_q;
        fifo_head         = empty ? 8'h00 : mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rd_hit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rd_hit_q <= rd_hit;
        end
    end

    assign fifo_full = full;
`else
    logic unused_fifo;

    assign unused_fifo = ^{push_valid, push_data, rd_en} ^ (FIFO_DEPTH == 0);
    assign ovf         = 1'b0;
    assign fifo_level  = 8'h00;
    assign fifo_head   = 8'h00;
    assign fifo_full   = 1'b1;
`endif

    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        mask_d    = mask_q;
        if (wr_en) begin
            case (off)
                16'd1:   scratch_d = wdata;
                16'd2:   ctrl_d    = wdata;
                16'd4:   mask_d    = wdata;
                default: ;
            endcase
        end
        // Sets are OR-ed in after the clear so a coincident event wins over W1C.
        status_d = (status_q & ~((wr_en && off == 16'd3) ? wdata : 8'h00)) | {ovf, evt};
        irq_d    = |(status_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch_q <= 8'h00;
            ctrl_q    <= 8'h00;
            status_q  <= 8'h00;
            mask_q    <= 8'h00;
            irq_q     <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        case (off)
            16'd0:   rdata = ID_VALUE;
            16'd1:   rdata = scratch_q;
            16'd2:   rdata = ctrl_q;
            16'd3:   rdata = status_q;
            16'd4:   rdata = mask_q;
            16'd5:   rdata = fifo_level;
            16'd6:   rdata = fifo_head;
            default: rdata = 8'h00;
        endcase
    end

    assign ctrl = ctrl_q;
    assign irq  = irq_q;

endmodule

// File: tb/tb_lbus_regfile.sv
// Directed bench for lbus_regfile; FIFO scenarios follow LBUS_REGFILE_FIFO_EN, otherwise the disabled-FIFO behaviour is checked.
module tb_lbus_regfile;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic        wr_en;
    logic [7:0]  wdata;
    logic        rd_en;
    logic [7:0]  rdata;
    logic [6:0]  evt;
    logic        push_valid;
    logic [7:0]  push_data;
    logic        fifo_full;
    logic [7:0]  ctrl;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lbus_regfile dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .wr_en      (wr_en),
        .wdata      (wdata),
        .rd_en      (rd_en),
        .rdata      (rdata),
        .evt        (evt),
        .push_valid (push_valid),
        .push_data  (push_data),
        .fifo_full  (fifo_full),
        .ctrl       (ctrl),
        .irq        (irq)
    );

    task automatic set_addr(input logic [15:0] a);
        address = a;
        #1;
    endtask

    task automatic reg_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        wdata   = d;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    // One burst read starting at FIFO_DATA, moving on to 0x07; returns the sampled head.
    task automatic rd_burst(output logic [7:0] d);
        @(negedge clk);
        address = 16'h0006;
        rd_en   = 1'b1;
        #1 d = rdata;
        @(negedge clk);
        address = 16'h0007;
        @(negedge clk);
        rd_en   = 1'b0;
        address = 16'h0000;
    endtask

    task automatic test_reset;
        logic [7:0] exp_tbl [8];
        exp_tbl = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        reset_n = 1'b0; address = '0; wr_en = 1'b0; wdata = '0; rd_en = 1'b0;
        evt = '0; push_valid = 1'b0; push_data = '0;
        #12;
        for (int i = 0; i < 8; i++) begin
            set_addr(16'(i));
            checks++; if (rdata !== exp_tbl[i]) begin errors++; $display("FAIL reset_read[%0d]: got %h exp %h", i, rdata, exp_tbl[i]); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b exp 0", irq); end
        checks++; if (ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %h exp 00", ctrl); end
`ifdef LBUS_REGFILE_FIFO_EN
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", fifo_full); end
`else
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL reset_full: got %b exp 1", fifo_full); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_regs;
        reg_write(16'h0001, 8'h3C);
        reg_write(16'h0002, 8'h81);
        reg_write(16'h0000, 8'h5A);
        reg_write(16'h0007, 8'hFF);
        set_addr(16'h0001);
        checks++; if (rdata !== 8'h3C) begin errors++; $display("FAIL scratch_rb: got %h exp 3c", rdata); end
        set_addr(16'h0002);
        checks++; if (rdata !== 8'h81) begin errors++; $display("FAIL ctrl_rb: got %h exp 81", rdata); end
        checks++; if (ctrl !== 8'h81) begin errors++; $display("FAIL ctrl_port: got %h exp 81", ctrl); end
        set_addr(16'h0000);
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL id_ro: got %h exp a5", rdata); end
        set_addr(16'h0007);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL unmapped: got %h exp 00", rdata); end
    endtask

    task automatic test_irq;
        reg_write(16'h0004, 8'h05);
        @(negedge clk);
        evt = 7'h04;
        @(negedge clk);
        evt = 7'h00;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b exp 0", irq); end
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h04) begin errors++; $display("FAIL status_set: got %h exp 04", rdata); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b exp 1", irq); end
        reg_write(16'h0003, 8'h04);
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL status_w1c: got %h exp 00", rdata); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b exp 0", irq); end
        // W1C of bit 2 while evt[2] pulses: the set must survive.
        @(negedge clk);
        address = 16'h0003; wdata = 8'h04; wr_en = 1'b1; evt = 7'h04;
        @(negedge clk);
        wr_en = 1'b0; evt = 7'h00;
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h04) begin errors++; $display("FAIL set_wins: got %h exp 04", rdata); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_after_coinc: got %b exp 1", irq); end
    endtask

`ifdef LBUS_REGFILE_FIFO_EN
    task automatic test_fifo;
        logic [7:0] d;
        reg_write(16'h0003, 8'hFF);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h03) begin errors++; $display("FAIL level3: got %h exp 03", rdata); end
        rd_burst(d);
        checks++; if (d !== 8'h11) begin errors++; $display("FAIL pop1: got %h exp 11", d); end
        rd_burst(d);
        checks++; if (d !== 8'h22) begin errors++; $display("FAIL pop2: got %h exp 22", d); end
        rd_burst(d);
        checks++; if (d !== 8'h33) begin errors++; $display("FAIL pop3: got %h exp 33", d); end
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL level0: got %h exp 00", rdata); end
        rd_burst(d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL empty_read: got %h exp 00", d); end
        @(negedge clk);
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL no_underflow: got %h exp 00", rdata); end
    endtask

    task automatic test_overflow;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            push_valid = 1'b1;
            push_data  = 8'h40 + 8'(i);
            @(negedge clk);
        end
        push_valid = 1'b0;
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL full: got %b exp 1", fifo_full); end
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h80) begin errors++; $display("FAIL ovf_status: got %h exp 80", rdata); end
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h08) begin errors++; $display("FAIL level8: got %h exp 08", rdata); end
        reg_write(16'h0003, 8'hFF);
        // Push lands on the same edge as the pop that completes this read.
        @(negedge clk);
        address = 16'h0006; rd_en = 1'b1;
        #1;
        checks++; if (rdata !== 8'h40) begin errors++; $display("FAIL full_head: got %h exp 40", rdata); end
        @(negedge clk);
        address = 16'h0007; push_valid = 1'b1; push_data = 8'h77;
        @(negedge clk);
        push_valid = 1'b0; rd_en = 1'b0;
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h08) begin errors++; $display("FAIL pushpop_level: got %h exp 08", rdata); end
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL pushpop_no_ovf: got %h exp 00", rdata); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pushpop_full: got %b exp 1", fifo_full); end
        set_addr(16'h0006);
        checks++; if (rdata !== 8'h41) begin errors++; $display("FAIL pushpop_head: got %h exp 41", rdata); end
    endtask
`else
    task automatic test_no_fifo;
        @(negedge clk);
        push_valid = 1'b1; push_data = 8'h99;
        repeat (3) @(negedge clk);
        push_valid = 1'b0;
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL nofifo_full: got %b exp 1", fifo_full); end
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL nofifo_level: got %h exp 00", rdata); end
        set_addr(16'h0006);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL nofifo_data: got %h exp 00", rdata); end
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h04) begin errors++; $display("FAIL nofifo_status: got %h exp 04", rdata); end
    endtask
`endif

    task automatic test_reset_mid_burst;
`ifdef LBUS_REGFILE_FIFO_EN
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h05) begin errors++; $display("FAIL level5: got %h exp 05", rdata); end
        reg_write(16'h0004, 8'h04);
        @(negedge clk);
        evt = 7'h04;
        @(negedge clk);
        evt = 7'h00;
        @(negedge clk);
`endif
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b exp 1", irq); end
        @(negedge clk);
        address = 16'h0006; rd_en = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq: got %b exp 0", irq); end
`ifdef LBUS_REGFILE_FIFO_EN
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL mid_reset_full: got %b exp 0", fifo_full); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h exp 00", rdata); end
`else
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL mid_reset_full: got %b exp 1", fifo_full); end
`endif
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mid_reset_level: got %h exp 00", rdata); end
        set_addr(16'h0003);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mid_reset_status: got %h exp 00", rdata); end
        set_addr(16'h0002);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL mid_reset_ctrl: got %h exp 00", rdata); end
        set_addr(16'h0000);
        checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL mid_reset_id: got %h exp a5", rdata); end
        rd_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        set_addr(16'h0005);
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL post_reset_level: got %h exp 00", rdata); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_irq();
`ifdef LBUS_REGFILE_FIFO_EN
        test_fifo();
        test_overflow();
`else
        test_no_fifo();
`endif
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
